// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared write-back select codes and register-file widths
package kgp_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [1:0] WB_SEL_RD = 2'd0;
    localparam logic [1:0] WB_SEL_RT = 2'd1;
    localparam logic [1:0] WB_SEL_RA = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - three-way round-robin pick starting at a pointer
module rr_pick3
    import kgp_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;

    // Scan order: ptr, ptr+1, ptr+2 (mod 3); an out-of-range pointer scans from 0
    always_comb begin
        p0 = WB_SEL_RD;
        p1 = WB_SEL_RT;
        p2 = WB_SEL_RA;
        case (ptr)
            2'd1: begin
                p0 = WB_SEL_RT;
                p1 = WB_SEL_RA;
                p2 = WB_SEL_RD;
            end
            2'd2: begin
                p0 = WB_SEL_RA;
                p1 = WB_SEL_RD;
                p2 = WB_SEL_RT;
            end
            default: ;
        endcase
    end

    // First valid requester in scan order wins
    always_comb begin
        idx   = WB_SEL_RD;
        found = 1'b0;
        grant = 3'b000;
        if (req[p0]) begin
            idx   = p0;
            found = 1'b1;
        end else if (req[p1]) begin
            idx   = p1;
            found = 1'b1;
        end else if (req[p2]) begin
            idx   = p2;
            found = 1'b1;
        end
        if (found) begin
            grant = 3'(3'b001 << idx);
        end
    end

endmodule

// File: rtl/regwb_arbiter.sv
// rtl/regwb_arbiter.sv - round-robin write-back port scheduler with one-entry output stage
module regwb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    input  logic              wr_stall,
    input  logic              flush,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    import kgp_pkg::*;

    logic              out_valid;
    logic [1:0]        rr_ptr;
    logic [2:0]        pick_grant;
    logic [1:0]        pick_idx;
    logic              pick_found;
    logic              can_accept;
    logic              take;
    logic              conflict;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_pick3 u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Stage is free, or its write drains this cycle; flush blocks any accept
    always_comb begin
        can_accept = !flush && (!out_valid || !wr_stall);
        take       = !rst && can_accept && pick_found;
        req_ready  = take ? pick_grant : 3'b000;
        wr_en      = !rst && out_valid && !wr_stall && !flush;
        busy       = out_valid;
        conflict   = (req_valid[0] & req_valid[1]) |
                     (req_valid[0] & req_valid[2]) |
                     (req_valid[1] & req_valid[2]);
    end

    // Route the granted requester's address and data into the stage
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (pick_idx)
            WB_SEL_RT: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            WB_SEL_RA: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: ;
        endcase
    end

    // Output stage: flush clears, accept loads (replacing a committing write), commit alone empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            wr_sel    <= WB_SEL_RD;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            wr_sel    <= pick_idx;
            wr_addr   <= sel_addr;
            wr_data   <= sel_data;
        end else if (wr_en) begin
            out_valid <= 1'b0;
        end
    end

    // Pointer moves just past the winner on each accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (take) begin
            rr_ptr <= (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
        end
    end

    // Saturating count of cycles with two or more requests pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule
